// File: rtl/mc_exec_sequencer.sv
// Fetch/decode/execute sequencer for the MC register file: saturating ALU, +/- test flag, tick-driven sleep.
// Define MC_EXEC_MUL_EN to build op 4 as a saturating multiply; otherwise op 4 decodes as NOP.
module mc_exec_sequencer #(
  parameter int DATA_W   = 11,
  parameter int ADDR_W   = 3,
  parameter int PC_W     = 4,
  parameter int PROG_LEN = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   pc,
  input  logic [23:0]       instr,
  input  logic              time_tick,
  output logic [ADDR_W-1:0] read_addr0,
  output logic [ADDR_W-1:0] read_addr1,
  input  logic [DATA_W-1:0] dat_in0,
  input  logic [DATA_W-1:0] dat_in1,
  output logic [DATA_W-1:0] write_dat,
  output logic [ADDR_W-1:0] write_addr,
  output logic              write_en,
  output logic [1:0]        test_flag,
  output logic              sleeping
);
  localparam int WIDE = 2*DATA_W + 1;
  localparam logic signed [WIDE-1:0] SAT_HI = WIDE'(999);
  localparam logic signed [WIDE-1:0] SAT_LO = WIDE'(-999);
  localparam logic [3:0] OP_MOV = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3, OP_MUL = 4'd4,
                         OP_NOT = 4'd5, OP_TEQ = 4'd6, OP_TGT = 4'd7, OP_TLT = 4'd8,
                         OP_SLP = 4'd9;
  localparam logic [1:0] FLAG_PLUS = 2'b01, FLAG_MINUS = 2'b10;

  typedef enum logic [1:0] {FETCH, EXEC, SLEEP} state_t;

  state_t                   state;
  logic [1:0]               ir_cond;
  logic [3:0]               ir_op;
  logic [2:0]               ir_dst;
  logic                     ir_bimm;
  logic signed [10:0]       ir_imm;
  logic [DATA_W-1:0]        sleep_cnt;

  logic signed [WIDE-1:0]   a_wide, b_wide, alu_res, sat_res;
  logic                     cond_ok, run, alu_wr, test_hit, is_test, slp_go;
  logic [ADDR_W-1:0]        alu_addr;

  assign a_wide = WIDE'($signed(dat_in0));
  assign b_wide = ir_bimm ? WIDE'(ir_imm) : WIDE'($signed(dat_in1));

  always_comb begin
    cond_ok = 1'b0;
    case (ir_cond)
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = (test_flag == FLAG_PLUS);
      2'b10:   cond_ok = (test_flag == FLAG_MINUS);
      default: cond_ok = 1'b0;
    endcase
  end

  assign run = (state == EXEC) && cond_ok;

  // Full-width result, clamped afterwards so nothing ever wraps.
  always_comb begin
    alu_wr   = 1'b0;
    alu_addr = '0;
    alu_res  = '0;
    case (ir_op)
      OP_MOV: begin alu_wr = 1'b1; alu_addr = ADDR_W'(ir_dst); alu_res = b_wide; end
      OP_ADD: begin alu_wr = 1'b1; alu_res = a_wide + b_wide; end
      OP_SUB: begin alu_wr = 1'b1; alu_res = a_wide - b_wide; end
`ifdef MC_EXEC_MUL_EN
      OP_MUL: begin alu_wr = 1'b1; alu_res = a_wide * b_wide; end
`endif
      OP_NOT: begin alu_wr = 1'b1; alu_res = (a_wide == WIDE'(0)) ? WIDE'(100) : WIDE'(0); end
      default: ;
    endcase
  end

  assign sat_res = (alu_res > SAT_HI) ? SAT_HI : ((alu_res < SAT_LO) ? SAT_LO : alu_res);

  always_comb begin
    test_hit = 1'b0;
    case (ir_op)
      OP_TEQ:  test_hit = (a_wide == b_wide);
      OP_TGT:  test_hit = (a_wide > b_wide);
      OP_TLT:  test_hit = (a_wide < b_wide);
      default: test_hit = 1'b0;
    endcase
  end

  assign is_test    = ir_op inside {OP_TEQ, OP_TGT, OP_TLT};
  assign slp_go     = run && (ir_op == OP_SLP) && !b_wide[WIDE-1] && (b_wide != WIDE'(0));
  assign write_en   = run && alu_wr;
  assign write_addr = write_en ? alu_addr : '0;
  assign write_dat  = write_en ? DATA_W'(sat_res) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= '0;
      read_addr0 <= '0;
      read_addr1 <= '0;
      test_flag  <= 2'b00;
      sleeping   <= 1'b0;
      sleep_cnt  <= '0;
      ir_cond    <= 2'b00;
      ir_op      <= 4'd0;
      ir_dst     <= 3'd0;
      ir_bimm    <= 1'b0;
      ir_imm     <= '0;
    end else begin
      case (state)
        FETCH: begin
          ir_cond    <= instr[23:22];
          ir_op      <= instr[21:18];
          ir_dst     <= instr[17:15];
          ir_bimm    <= instr[11];
          ir_imm     <= instr[10:0];
          // Accumulator ops always take operand A from acc, regardless of srcA.
          read_addr0 <= (instr[21:18] inside {OP_ADD, OP_SUB, OP_MUL, OP_NOT})
                        ? '0 : ADDR_W'(instr[14:12]);
          read_addr1 <= ADDR_W'(instr[2:0]);
          state      <= EXEC;
        end
        EXEC: begin
          pc <= (pc == PC_W'(PROG_LEN - 1)) ? '0 : pc + PC_W'(1);
          if (run && is_test)
            test_flag <= test_hit ? FLAG_PLUS : FLAG_MINUS;
          if (slp_go) begin
            sleep_cnt <= DATA_W'(b_wide);
            sleeping  <= 1'b1;
            state     <= SLEEP;
          end else begin
            state <= FETCH;
          end
        end
        SLEEP: begin
          if (time_tick) begin
            sleep_cnt <= sleep_cnt - DATA_W'(1);
            if (sleep_cnt == DATA_W'(1)) begin
              sleeping <= 1'b0;
              state    <= FETCH;
            end
          end
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_exec_sequencer.sv
// Bench for mc_exec_sequencer: directed instruction table, reset-in-sleep sequence, and random programs
// checked against an instruction-level model of the architectural registers and flag.
`timescale 1ns/1ps
module tb_mc_exec_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  pc;
  logic [23:0] instr;
  logic        time_tick = 1'b0;
  logic [2:0]  read_addr0, read_addr1, write_addr;
  logic [10:0] dat_in0, dat_in1, write_dat;
  logic        write_en;
  logic [1:0]  test_flag;
  logic        sleeping;

  logic [23:0] rom [0:15];
  logic [10:0] regs [0:7];
  logic        clr = 1'b1;

  int          checks = 0;
  int          failures = 0;
  int          mpc;
  logic [1:0]  mflag;
  int          mregs [0:7];

  typedef struct {
    logic [23:0] ins;
    logic        we;
    logic [2:0]  addr;
    int          dat;
    logic [1:0]  flag;
    int          sl;
  } vec_t;
  vec_t tbl [0:23];

  mc_exec_sequencer dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr), .time_tick(time_tick),
    .read_addr0(read_addr0), .read_addr1(read_addr1), .dat_in0(dat_in0), .dat_in1(dat_in1),
    .write_dat(write_dat), .write_addr(write_addr), .write_en(write_en),
    .test_flag(test_flag), .sleeping(sleeping)
  );

  always #5 clk = ~clk;

  assign instr   = rom[pc];
  assign dat_in0 = regs[read_addr0];
  assign dat_in1 = regs[read_addr1];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (write_en) begin
      regs[write_addr] <= write_dat;
    end
  end

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [23:0] enc(input int c, input int op, input int dst, input int sa,
                                      input int bi, input int imm);
    return {c[1:0], op[3:0], dst[2:0], sa[2:0], bi[0], imm[10:0]};
  endfunction

  function automatic int sat(input int v);
    return (v > 999) ? 999 : ((v < -999) ? -999 : v);
  endfunction

  // Architectural effect of one instruction, from the current model registers and flag.
  task automatic model(input logic [23:0] ins, output logic we, output logic [2:0] wa,
                       output int wd, output logic [1:0] fl, output int sl);
    int op, a, b, acc;
    bit run;
    op  = int'(ins[21:18]);
    acc = mregs[0];
    a   = mregs[ins[14:12]];
    b   = ins[11] ? int'($signed(ins[10:0])) : mregs[ins[2:0]];
    case (ins[23:22])
      2'b00:   run = 1'b1;
      2'b01:   run = (mflag == 2'b01);
      2'b10:   run = (mflag == 2'b10);
      default: run = 1'b0;
    endcase
    we = 1'b0; wa = 3'd0; wd = 0; fl = mflag; sl = 0;
    if (run) begin
      case (op)
        1: begin we = 1'b1; wa = ins[17:15]; wd = sat(b); end
        2: begin we = 1'b1; wd = sat(acc + b); end
        3: begin we = 1'b1; wd = sat(acc - b); end
`ifdef MC_EXEC_MUL_EN
        4: begin we = 1'b1; wd = sat(acc * b); end
`endif
        5: begin we = 1'b1; wd = (acc == 0) ? 100 : 0; end
        6: fl = (a == b) ? 2'b01 : 2'b10;
        7: fl = (a > b)  ? 2'b01 : 2'b10;
        8: fl = (a < b)  ? 2'b01 : 2'b10;
        9: sl = (b > 0) ? b : 0;
        default: ;
      endcase
    end
  endtask

  // Entered at the negedge inside a FETCH cycle; returns at the negedge inside the next FETCH cycle.
  task automatic do_instr(input string tag, input logic [23:0] ins, input logic ewe, input logic [2:0] ea,
                          input int ed, input logic [1:0] ef, input int esl);
    int ticks, guard;
    rom[mpc[3:0]] = ins;
    chk({tag, " fetch pc"}, pc, mpc);
    chk({tag, " fetch flag"}, test_flag, mflag);
    chk({tag, " fetch sleeping"}, sleeping, 0);
    chk({tag, " fetch write_en"}, write_en, 0);
    @(negedge clk);
    chk({tag, " exec write_en"}, write_en, ewe);
    if (ewe) begin
      chk({tag, " exec write_addr"}, write_addr, ea);
      chk({tag, " exec write_dat"}, $signed(write_dat), ed);
      mregs[ea] = ed;
    end
    time_tick = ($urandom % 2 == 0);
    if (esl > 0) begin
      ticks = 0;
      guard = 0;
      while (ticks < esl && guard < 20 * esl + 20) begin
        @(negedge clk);
        chk({tag, " sleeping"}, sleeping, 1);
        time_tick = ($urandom % 3 == 0);
        if (time_tick) ticks++;
        guard++;
      end
      if (ticks < esl) chk({tag, " sleep tick budget"}, ticks, esl);
    end
    @(negedge clk);
    time_tick = ($urandom % 2 == 0);
    mpc   = (mpc + 1) % 9;
    mflag = ef;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr = 1'b1;
    time_tick = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset pc", pc, 0);
    chk("reset read_addr0", read_addr0, 0);
    chk("reset read_addr1", read_addr1, 0);
    chk("reset write_dat", write_dat, 0);
    chk("reset write_addr", write_addr, 0);
    chk("reset write_en", write_en, 0);
    chk("reset test_flag", test_flag, 0);
    chk("reset sleeping", sleeping, 0);
    clr = 1'b0;
    rst_n = 1'b1;
    mpc = 0;
    mflag = 2'b00;
    for (int i = 0; i < 8; i++) mregs[i] = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] fm;
    logic       we;
    logic [2:0] wa;
    int         wd, sl, c, op, dst, sa, bi, imm;
    logic [1:0] fl;
    logic [23:0] ins;

`ifdef MC_EXEC_MUL_EN
    fm = 2'b10;
`else
    fm = 2'b01;
`endif
    tbl[0]  = '{enc(0, 1, 0, 0, 1, 5),     1'b1, 3'd0, 5,    2'b00, 0};
    tbl[1]  = '{enc(0, 2, 0, 0, 1, 7),     1'b1, 3'd0, 12,   2'b00, 0};
    tbl[2]  = '{enc(0, 6, 0, 0, 1, 12),    1'b0, 3'd0, 0,    2'b01, 0};
    tbl[3]  = '{enc(1, 1, 2, 0, 1, 1),     1'b1, 3'd2, 1,    2'b01, 0};
    tbl[4]  = '{enc(2, 1, 3, 0, 1, 2),     1'b0, 3'd0, 0,    2'b01, 0};
    tbl[5]  = '{enc(0, 1, 0, 0, 1, 990),   1'b1, 3'd0, 990,  2'b01, 0};
    tbl[6]  = '{enc(0, 2, 0, 0, 1, 20),    1'b1, 3'd0, 999,  2'b01, 0};
    tbl[7]  = '{enc(0, 7, 0, 0, 1, 1000),  1'b0, 3'd0, 0,    2'b10, 0};
    tbl[8]  = '{enc(0, 2, 0, 0, 1, 1),     1'b1, 3'd0, 999,  2'b10, 0};
    tbl[9]  = '{enc(0, 1, 0, 0, 1, -990),  1'b1, 3'd0, -990, 2'b10, 0};
    tbl[10] = '{enc(0, 3, 0, 0, 1, 20),    1'b1, 3'd0, -999, 2'b10, 0};
    tbl[11] = '{enc(2, 5, 0, 0, 1, 0),     1'b1, 3'd0, 0,    2'b10, 0};
    tbl[12] = '{enc(0, 5, 0, 0, 1, 0),     1'b1, 3'd0, 100,  2'b10, 0};
    tbl[13] = '{enc(0, 1, 3, 0, 0, 0),     1'b1, 3'd3, 100,  2'b10, 0};
`ifdef MC_EXEC_MUL_EN
    tbl[14] = '{enc(0, 4, 0, 0, 1, 30),    1'b1, 3'd0, 999,  2'b10, 0};
    tbl[18] = '{enc(0, 3, 0, 0, 0, 3),     1'b1, 3'd0, 899,  fm,    0};
    tbl[19] = '{enc(0, 2, 0, 0, 1, -1024), 1'b1, 3'd0, -125, fm,    0};
`else
    tbl[14] = '{enc(0, 4, 0, 0, 1, 30),    1'b0, 3'd0, 0,    2'b10, 0};
    tbl[18] = '{enc(0, 3, 0, 0, 0, 3),     1'b1, 3'd0, 0,    fm,    0};
    tbl[19] = '{enc(0, 2, 0, 0, 1, -1024), 1'b1, 3'd0, -999, fm,    0};
`endif
    tbl[15] = '{enc(0, 6, 0, 3, 0, 0),     1'b0, 3'd0, 0,    fm,    0};
    tbl[16] = '{enc(3, 1, 0, 0, 1, 7),     1'b0, 3'd0, 0,    fm,    0};
    tbl[17] = '{enc(0, 12, 0, 0, 1, 0),    1'b0, 3'd0, 0,    fm,    0};
    tbl[20] = '{enc(0, 9, 0, 0, 1, 3),     1'b0, 3'd0, 0,    fm,    3};
    tbl[21] = '{enc(0, 9, 0, 0, 1, -2),    1'b0, 3'd0, 0,    fm,    0};
    tbl[22] = '{enc(3, 9, 0, 0, 1, 4),     1'b0, 3'd0, 0,    fm,    0};
    tbl[23] = '{enc(0, 9, 0, 0, 1, 1),     1'b0, 3'd0, 0,    fm,    1};

    for (int i = 0; i < 16; i++) rom[i] = 24'h0;
    do_reset();

    for (int i = 0; i < 24; i++)
      do_instr($sformatf("tbl%0d", i), tbl[i].ins, tbl[i].we, tbl[i].addr, tbl[i].dat, tbl[i].flag, tbl[i].sl);

    // Reset pulled in the middle of a sleep must take effect without waiting for a clock edge.
    rom[mpc[3:0]] = enc(0, 9, 0, 0, 1, 5);
    chk("rst_sleep fetch pc", pc, mpc);
    time_tick = 1'b0;
    @(negedge clk);
    chk("rst_sleep exec write_en", write_en, 0);
    @(negedge clk);
    chk("rst_sleep sleeping", sleeping, 1);
    time_tick = 1'b1;
    @(negedge clk);
    time_tick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sleep async pc", pc, 0);
    chk("rst_sleep async sleeping", sleeping, 0);
    chk("rst_sleep async test_flag", test_flag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mpc = 0;
    mflag = 2'b00;
    do_instr("after_rst", enc(0, 1, 0, 0, 1, 3), 1'b1, 3'd0, 3, 2'b00, 0);

    do_reset();
    for (int n = 0; n < 300; n++) begin
      c   = ($urandom % 2 == 0) ? 0 : int'($urandom % 4);
      op  = int'($urandom % 16);
      dst = int'($urandom % 8);
      sa  = int'($urandom % 8);
      bi  = int'($urandom % 2);
      case ($urandom % 8)
        0:       imm = 1023;
        1:       imm = -1024;
        default: imm = int'($urandom_range(1998, 0)) - 999;
      endcase
      if (bi == 0) imm = int'($urandom % 8);
      if (op == 9) begin
        bi  = 1;
        imm = int'($urandom_range(8, 0)) - 3;
      end
      ins = enc(c, op, dst, sa, bi, imm);
      model(ins, we, wa, wd, fl, sl);
      do_instr($sformatf("rnd%0d", n), ins, we, wa, wd, fl, sl);
    end
    chk("final flag", test_flag, mflag);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
